// File: rtl/scatter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : scatter                                                      |
// | Purpose  : FIFO-buffered task distributor feeding two solver cores with |
// |            round-robin/fallback dispatch and per-core in-flight credits |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module scatter #(
    parameter int WIDTH        = 40,
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [WIDTH-1:0]                  m_data,
    input  logic                              m_valid,
    output logic                              m_ready,
    output logic [WIDTH-1:0]                  s0_data,
    output logic                              s0_valid,
    input  logic                              s0_ready,
    input  logic                              s0_done,
    output logic [WIDTH-1:0]                  s1_data,
    output logic                              s1_valid,
    input  logic                              s1_ready,
    input  logic                              s1_done,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight0,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight1,
    output logic                              idle,
    output logic                              error
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_iw = $clog2(MAX_INFLIGHT + 1);
    localparam logic [c_cw-1:0] c_full_cnt = c_cw'(DEPTH);
    localparam logic [c_iw:0]   c_max_ext  = (c_iw + 1)'(MAX_INFLIGHT);

    // FIFO storage and pointers
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;

    // Output registers, credit counters, arbitration and status
    logic [WIDTH-1:0] s0_data_q, s0_data_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s0_valid_q, s0_valid_d;
    logic             s1_valid_q, s1_valid_d;
    logic [c_iw-1:0]  inflight0_q, inflight0_d;
    logic [c_iw-1:0]  inflight1_q, inflight1_d;
    logic             prio_q, prio_d;
    logic             error_q, error_d;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_dispatch;
    logic             w_sel;
    logic             w_hs0, w_hs1;
    logic             w_free0, w_free1;
    logic             w_credit0, w_credit1;
    logic             w_elig0, w_elig1;
    logic [c_iw:0]    w_load0, w_load1;
    logic [WIDTH-1:0] w_head;

    assign w_full  = (count_q == c_full_cnt);
    assign w_empty = (count_q == '0);
    assign w_push  = m_valid && !w_full;
    assign w_head  = mem_q[rd_ptr_q];

    assign w_hs0 = s0_valid_q && s0_ready;
    assign w_hs1 = s1_valid_q && s1_ready;

    // Credit counts both accepted-not-done tasks and the one parked in the output register
    assign w_load0   = {1'b0, inflight0_q} + {{c_iw{1'b0}}, s0_valid_q};
    assign w_load1   = {1'b0, inflight1_q} + {{c_iw{1'b0}}, s1_valid_q};
    assign w_credit0 = (w_load0 < c_max_ext);
    assign w_credit1 = (w_load1 < c_max_ext);
    assign w_free0   = !s0_valid_q || s0_ready;
    assign w_free1   = !s1_valid_q || s1_ready;
    assign w_elig0   = w_free0 && w_credit0;
    assign w_elig1   = w_free1 && w_credit1;

    // w_sel: 0 targets core 0, 1 targets core 1
    assign w_dispatch = !w_empty && (w_elig0 || w_elig1);
    assign w_sel      = (w_elig0 && w_elig1) ? prio_q : w_elig1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        prio_d   = prio_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_aw'(1);
        end
        if (w_dispatch) begin
            rd_ptr_d = rd_ptr_q + c_aw'(1);
            prio_d   = !w_sel;
        end

        case ({w_push, w_dispatch})
            2'b10:   count_d = count_q + c_cw'(1);
            2'b01:   count_d = count_q - c_cw'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_data_d  = s0_data_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;

        if (w_dispatch && !w_sel) begin
            s0_valid_d = 1'b1;
            s0_data_d  = w_head;
        end else if (s0_ready) begin
            s0_valid_d = 1'b0;
        end

        if (w_dispatch && w_sel) begin
            s1_valid_d = 1'b1;
            s1_data_d  = w_head;
        end else if (s1_ready) begin
            s1_valid_d = 1'b0;
        end
    end

    // A done with nothing outstanding leaves the counter at zero and latches the error
    always_comb begin
        inflight0_d = inflight0_q;
        inflight1_d = inflight1_q;
        error_d     = error_q;

        if (w_hs0 && !s0_done) begin
            inflight0_d = inflight0_q + c_iw'(1);
        end else if (s0_done && !w_hs0) begin
            if (inflight0_q == '0) begin
                error_d = 1'b1;
            end else begin
                inflight0_d = inflight0_q - c_iw'(1);
            end
        end

        if (w_hs1 && !s1_done) begin
            inflight1_d = inflight1_q + c_iw'(1);
        end else if (s1_done && !w_hs1) begin
            if (inflight1_q == '0) begin
                error_d = 1'b1;
            end else begin
                inflight1_d = inflight1_q - c_iw'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s0_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s0_data_q   <= '0;
            s1_data_q   <= '0;
            inflight0_q <= '0;
            inflight1_q <= '0;
            prio_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s0_valid_q  <= s0_valid_d;
            s1_valid_q  <= s1_valid_d;
            s0_data_q   <= s0_data_d;
            s1_data_q   <= s1_data_d;
            inflight0_q <= inflight0_d;
            inflight1_q <= inflight1_d;
            prio_q      <= prio_d;
            error_q     <= error_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= m_data;
        end
    end

    assign m_ready   = !w_full;
    assign s0_data   = s0_data_q;
    assign s0_valid  = s0_valid_q;
    assign s1_data   = s1_data_q;
    assign s1_valid  = s1_valid_q;
    assign count     = count_q;
    assign inflight0 = inflight0_q;
    assign inflight1 = inflight1_q;
    assign error     = error_q;
    assign idle      = w_empty && !s0_valid_q && !s1_valid_q &&
                       (inflight0_q == '0) && (inflight1_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_scatter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_scatter                                                   |
// | Purpose  : Randomized self-checking bench for scatter against a         |
// |            queue-based reference model                                  |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module tb_scatter;

    localparam int WIDTH = 40;
    localparam int DEPTH = 4;
    localparam int MAXI  = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(MAXI + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] m_data = '0;
    logic             m_valid = 1'b0;
    logic             m_ready;
    logic [WIDTH-1:0] s0_data, s1_data;
    logic             s0_valid, s1_valid;
    logic             s0_ready = 1'b0, s1_ready = 1'b0;
    logic             s0_done = 1'b0, s1_done = 1'b0;
    logic [CW-1:0]    count;
    logic [IW-1:0]    inflight0, inflight1;
    logic             idle, error;

    always #5 clock = ~clock;

    scatter #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_done  (s0_done),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_done  (s1_done),
        .count    (count),
        .inflight0(inflight0),
        .inflight1(inflight1),
        .idle     (idle),
        .error    (error)
    );

    // Reference model state: pending tasks, parked task per core, outstanding counts
    logic [WIDTH-1:0] mq[$];
    bit               mv[2];
    logic [WIDTH-1:0] md[2];
    int               mi[2];
    bit               mprio;
    bit               merr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("m_ready",   64'(m_ready),   64'(mq.size() < DEPTH));
        check_eq("count",     64'(count),     64'(mq.size()));
        check_eq("s0_valid",  64'(s0_valid),  64'(mv[0]));
        check_eq("s1_valid",  64'(s1_valid),  64'(mv[1]));
        if (mv[0]) check_eq("s0_data", 64'(s0_data), 64'(md[0]));
        if (mv[1]) check_eq("s1_data", 64'(s1_data), 64'(md[1]));
        check_eq("inflight0", 64'(inflight0), 64'(mi[0]));
        check_eq("inflight1", 64'(inflight1), 64'(mi[1]));
        check_eq("idle",      64'(idle),
                 64'(mq.size() == 0 && !mv[0] && !mv[1] && mi[0] == 0 && mi[1] == 0));
        check_eq("error",     64'(error),     64'(merr));
    endtask

    task automatic model_update(input bit rst, input bit v, input logic [WIDTH-1:0] d,
                                input bit r0, input bit r1, input bit d0, input bit d1);
        bit rdy[2];
        bit dn[2];
        bit hs[2];
        bit elig[2];
        bit can_push;
        int sel;
        if (rst) begin
            mq.delete();
            mv[0] = 0; mv[1] = 0;
            mi[0] = 0; mi[1] = 0;
            mprio = 0;
            merr  = 0;
            return;
        end
        rdy[0] = r0; rdy[1] = r1;
        dn[0]  = d0; dn[1]  = d1;
        can_push = (mq.size() < DEPTH);
        for (int k = 0; k < 2; k++) begin
            hs[k]   = mv[k] && rdy[k];
            elig[k] = (!mv[k] || rdy[k]) && (mi[k] + int'(mv[k]) < MAXI);
        end
        sel = -1;
        if (mq.size() > 0) begin
            if (elig[0] && elig[1]) sel = int'(mprio);
            else if (elig[0])       sel = 0;
            else if (elig[1])       sel = 1;
        end
        for (int k = 0; k < 2; k++) begin
            if (sel == k) begin
                mv[k] = 1;
                md[k] = mq.pop_front();
            end else if (rdy[k]) begin
                mv[k] = 0;
            end
        end
        if (sel >= 0) mprio = (sel == 0);
        for (int k = 0; k < 2; k++) begin
            if (hs[k] && !dn[k]) begin
                mi[k]++;
            end else if (dn[k] && !hs[k]) begin
                if (mi[k] == 0) merr = 1;
                else            mi[k]--;
            end
        end
        if (v && can_push) mq.push_back(d);
    endtask

    // One clock: check outputs mid-cycle, drive this cycle's inputs, advance the model at the edge
    task automatic step(input bit rst, input bit v, input logic [WIDTH-1:0] d,
                        input bit r0, input bit r1, input bit d0, input bit d1, input bit chk);
        @(negedge clock);
        if (chk) compare_all();
        reset    = rst;
        m_valid  = v;
        m_data   = d;
        s0_ready = r0;
        s1_ready = r1;
        s0_done  = d0;
        s1_done  = d1;
        @(posedge clock);
        model_update(rst, v, d, r0, r1, d0, d1);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return {8'($urandom), $urandom};
    endfunction

    // Per-phase percentages: valid, s0_ready, s1_ready, done, illegal-done enable, reset
    int ph_pv [5] = '{90,  90, 95, 60, 70};
    int ph_pr0[5] = '{90,   0, 10, 70, 60};
    int ph_pr1[5] = '{90,  80, 10, 70, 60};
    int ph_pd [5] = '{30,  40, 10, 50, 30};
    int ph_ill[5] = '{0,    0,  0,  1,  0};
    int ph_rst[5] = '{0,    0,  0,  0,  2};

    initial begin
        bit v, r0, r1, d0, d1, rst;
        step(1, 0, '0, 0, 0, 0, 0, 0);

        // Two back-to-back pushes into an idle block with both cores ready
        step(0, 1, 40'hA0A0A0A0A0, 1, 1, 0, 0, 1);
        step(0, 1, 40'hB1B1B1B1B1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1, 0, 0, 1);

        for (int p = 0; p < 5; p++) begin
            step(1, 0, '0, 0, 0, 0, 0, 1);
            for (int c = 0; c < 600; c++) begin
                v   = ($urandom_range(99) < ph_pv[p]);
                r0  = ($urandom_range(99) < ph_pr0[p]);
                r1  = ($urandom_range(99) < ph_pr1[p]);
                d0  = ($urandom_range(99) < ph_pd[p]) && (ph_ill[p] != 0 || mi[0] > 0);
                d1  = ($urandom_range(99) < ph_pd[p]) && (ph_ill[p] != 0 || mi[1] > 0);
                rst = ($urandom_range(99) < ph_rst[p]);
                step(rst, v, rand_word(), r0, r1, d0, d1, 1);
            end
        end

        // Fill while both cores stall, then drain with no further traffic
        step(1, 0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 1, rand_word(), 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            d0 = (mi[0] > 0);
            d1 = (mi[1] > 0);
            step(0, 0, '0, 1, 1, d0, d1, 1);
        end

        @(negedge clock);
        compare_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
